// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the commit trace buffer: record layout and control states.
package commit_trace_buffer_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        ebreak;
    logic        mmio;
  } commit_rec_t;

  localparam int REC_W = $bits(commit_rec_t);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } ctb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered pointers and an occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is cleared on reset so the head read is never X while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-record buffer between the core's commit stage and a trace reader,
// with halt-on-ebreak tracking and a no-commit watchdog.
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmt_valid,
  input  logic [31:0] cmt_pc,
  input  logic        cmt_ebreak,
  input  logic        cmt_mmio,
  output logic        cmt_ready,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic        trace_ebreak,
  output logic        trace_mmio,
  input  logic        trace_ready,
  output logic        halted,
  output logic        hang,
  output logic [31:0] cmt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

  ctb_state_e  state, state_nxt;
  commit_rec_t wr_rec, head;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  logic        push, pop;
  logic [IW-1:0] idle_cnt;

  assign wr_rec = '{pc: cmt_pc, ebreak: cmt_ebreak, mmio: cmt_mmio};

  // Ready depends only on local state so the reader never reaches the core combinationally.
  assign cmt_ready   = (state == RUN) & ~fifo_full;
  assign trace_valid = ~fifo_empty & (state != HALT);
  assign push        = cmt_valid & cmt_ready;
  assign pop         = trace_valid & trace_ready;

  assign trace_pc     = head.pc;
  assign trace_ebreak = head.ebreak;
  assign trace_mmio   = head.mmio;
  assign halted       = (state == HALT);

  sync_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_rec),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  fifo_count_consistent: assert property (@(posedge clk) disable iff (rst)
    (fifo_count == '0) == fifo_empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Once the ebreak is taken nothing else enters, so its pop empties the FIFO.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (push && cmt_ebreak)  state_nxt = DRAIN;
      DRAIN:   if (pop && trace_ebreak) state_nxt = HALT;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmt_count <= '0;
    end else if (push) begin
      cmt_count <= cmt_count + 32'd1;
    end
  end

  // Backpressure stalls count as idle, so a stuck reader also trips the watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      hang     <= 1'b0;
    end else if (state == RUN) begin
      if (push)                      idle_cnt <= '0;
      else if (idle_cnt == IDLE_MAX) hang     <= 1'b1;
      else                           idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomised + directed bench: queue-based reference model and a popped-record scoreboard.
module tb_commit_trace_buffer;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [31:0] pc;
    logic        eb;
    logic        mm;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmt_valid = 1'b0;
  logic [31:0] cmt_pc = '0;
  logic        cmt_ebreak = 1'b0;
  logic        cmt_mmio = 1'b0;
  logic        cmt_ready;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic        trace_ebreak;
  logic        trace_mmio;
  logic        trace_ready = 1'b0;
  logic        halted;
  logic        hang;
  logic [31:0] cmt_count;

  int n_chk  = 0;
  int n_pass = 0;

  commit_trace_buffer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmt_valid    (cmt_valid),
    .cmt_pc       (cmt_pc),
    .cmt_ebreak   (cmt_ebreak),
    .cmt_mmio     (cmt_mmio),
    .cmt_ready    (cmt_ready),
    .trace_valid  (trace_valid),
    .trace_pc     (trace_pc),
    .trace_ebreak (trace_ebreak),
    .trace_mmio   (trace_mmio),
    .trace_ready  (trace_ready),
    .halted       (halted),
    .hang         (hang),
    .cmt_count    (cmt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: FIFO contents as a queue, mode flags, idle counter, sticky hang.
  rec_t        mq[$];
  rec_t        sb[$];
  bit          m_drain, m_halt, m_hang;
  int          m_idle;
  logic [31:0] m_cnt;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete(); sb.delete();
      m_drain = 0; m_halt = 0; m_hang = 0; m_idle = 0; m_cnt = '0;
    end else begin
      bit   run, e_ready, e_tv, do_push, do_pop;
      rec_t r;
      run     = !m_drain && !m_halt;
      e_ready = run && (mq.size() < DEPTH);
      e_tv    = (mq.size() > 0) && !m_halt;
      chk("cmt_ready",   cmt_ready,   e_ready);
      chk("trace_valid", trace_valid, e_tv);
      chk("halted",      halted,      m_halt);
      chk("hang",        hang,        m_hang);
      chk("cmt_count",   cmt_count,   m_cnt);
      do_push = cmt_valid && e_ready;
      do_pop  = e_tv && trace_ready;
      if (do_pop) begin
        r = mq.pop_front();
        if (m_drain && r.eb) begin m_drain = 0; m_halt = 1; end
      end
      if (do_push) begin
        r = '{pc: cmt_pc, eb: cmt_ebreak, mm: cmt_mmio};
        mq.push_back(r);
        sb.push_back(r);
        m_cnt = m_cnt + 1;
        if (cmt_ebreak) m_drain = 1;
      end
      if (run) begin
        if (do_push)                   m_idle = 0;
        else if (m_idle == TIMEOUT-1)  m_hang = 1;
        else                           m_idle++;
      end
    end
  end

  // Monitor: every record the DUT hands over must be the oldest accepted one.
  always @(negedge clk) begin
    #1;
    if (!rst && trace_valid && trace_ready) begin
      rec_t e;
      if (sb.size() == 0) begin
        chk("pop_without_record", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("trace_pc",     trace_pc,     e.pc);
        chk("trace_ebreak", trace_ebreak, e.eb);
        chk("trace_mmio",   trace_mmio,   e.mm);
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] pc, input logic eb,
                      input logic mm, input logic tr);
    cmt_valid = v; cmt_pc = pc; cmt_ebreak = eb; cmt_mmio = mm; trace_ready = tr;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    cmt_valid = 0; trace_ready = 0; cmt_ebreak = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL tb_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    bit          done;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_cmt_ready",    cmt_ready,    1);
    chk("rst_trace_valid",  trace_valid,  0);
    chk("rst_trace_pc",     trace_pc,     0);
    chk("rst_trace_ebreak", trace_ebreak, 0);
    chk("rst_trace_mmio",   trace_mmio,   0);
    chk("rst_halted",       halted,       0);
    chk("rst_hang",         hang,         0);
    chk("rst_cmt_count",    cmt_count,    0);

    // Back-to-back pushes with an always-ready reader.
    for (int i = 0; i < 3; i++) step(1, 32'h8000_0000 + 32'(4*i), 0, 0, 1);
    chk("three_count", cmt_count, 3);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

    // Fill, stall the 9th, release with one pop, then drain across the wrap.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 32'h8000_0100 + 32'(4*i), 0, i[0], 0);
    chk("full_not_ready", cmt_ready, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h8000_0120, 0, 1, 0);
    step(1, 32'h8000_0120, 0, 1, 1);
    chk("ready_after_pop", cmt_ready, 1);
    step(1, 32'h8000_0120, 0, 1, 0);
    chk("ninth_count", cmt_count, 9);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);

    // Full FIFO with core and reader both active.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 32'h8000_0200 + 32'(4*i), 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 32'h8000_0300 + 32'(4*i), 0, i[1], 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);

    // Random traffic, no ebreak.
    do_reset();
    for (int ph = 0; ph < 6; ph++) begin
      int rp, vp;
      rp = $urandom_range(10, 100);
      vp = $urandom_range(20, 100);
      for (int i = 0; i < 60; i++)
        step($urandom_range(1, 100) <= vp, $urandom, 0, $urandom_range(0, 1),
             $urandom_range(1, 100) <= rp);
    end

    // Ebreak: later records refused, halt once the ebreak is popped.
    do_reset();
    step(1, 32'h8000_0008, 0, 0, 0);
    step(1, 32'h8000_000c, 0, 1, 0);
    step(1, 32'h8000_0010, 1, 0, 0);
    chk("ebreak_not_ready", cmt_ready, 0);
    step(1, 32'h8000_0014, 0, 0, 0);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1, 32'h8000_0014, 0, 0, 1);
      done = halted;
    end
    chk("halt_reached",   halted,      1);
    chk("halt_no_valid",  trace_valid, 0);
    chk("halt_count",     cmt_count,   3);

    // Watchdog with no commits.
    do_reset();
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0);
    chk("hang_before", hang, 0);
    step(0, 0, 0, 0, 0);
    chk("hang_at_timeout", hang, 1);
    step(1, 32'h8000_0400, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("hang_sticky", hang, 1);
    do_reset();
    chk("hang_cleared", hang, 0);

    // Asynchronous reset in DRAIN with five entries.
    for (int i = 0; i < 4; i++) step(1, 32'h8000_0500 + 32'(4*i), 0, 0, 0);
    step(1, 32'h8000_0510, 1, 0, 0);
    chk("drain_not_ready", cmt_ready, 0);
    chk("drain_count",     cmt_count, 5);
    cmt_valid = 0;
    #2 rst = 1;
    #1;
    chk("async_trace_valid", trace_valid, 0);
    chk("async_halted",      halted,      0);
    chk("async_cmt_count",   cmt_count,   0);
    chk("async_ready_run",   cmt_ready,   1);
    @(posedge clk); #1;
    rst = 0;
    step(1, 32'h8000_0600, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
